tanh_input_unpacker: RTL

//   Upstream feeder for the Tanh activation stage. Accepts packed LANES x 32-bit

---
 rtl/tanh_input_unpacker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tanh_input_unpacker.sv
// Tanh input unpacker: takes packed LANES-wide words from the memory read
// stream and serializes them into one element per cycle for the Tanh stage.
// It emits exactly num_elems elements, flags the last one and pulses done
// at the end of the job.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; no words accepted, no elements presented
//   RUN   | job active; accepting words and emitting elements in order
module tanh_input_unpacker #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_elems,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [CNT_W-1:0]          out_index
);

  localparam int             LG        = $clog2(LANES);
  localparam logic [LG-1:0]  LAST_LANE = LG'(LANES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                        state_q;
  logic [CNT_W-1:0]              num_q;
  logic [CNT_W-1:0]              words_tot_q;
  logic [CNT_W-1:0]              words_taken_q;
  logic [CNT_W-1:0]              index_q;
  logic [LANES-1:0][DATA_W-1:0]  buf_q;
  logic                          buf_valid_q;
  logic [LG-1:0]                 lane_q;
  logic                          done_q;

  logic [CNT_W:0]                num_round;
  logic [CNT_W-1:0]              words_tot_d;
  logic                          out_fire;
  logic                          is_last_elem;
  logic                          word_release;
  logic                          in_fire;

  // Word count for the job, ceil(num_elems / LANES); one extra bit so the
  // rounding add cannot overflow at the maximum element count.
  assign num_round   = {1'b0, num_elems} + (CNT_W + 1)'(LANES - 1);
  assign words_tot_d = CNT_W'(num_round >> LG);

  // The buffered word is released after its last used lane: lane LANES-1 of
  // a full word, or the final element of the job inside a partial word.
  assign out_fire     = buf_valid_q && out_ready;
  assign is_last_elem = (index_q == num_q - 1'b1);
  assign word_release = out_fire && ((lane_q == LAST_LANE) || is_last_elem);

  // Refill in the same cycle the buffer drains so a full-rate stream never
  // bubbles; this is why in_ready depends combinationally on out_ready.
  assign in_ready = (state_q == S_RUN) && (words_taken_q < words_tot_q) &&
                    (!buf_valid_q || word_release);
  assign in_fire  = in_valid && in_ready;

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign out_valid = buf_valid_q;
  assign out_data  = buf_q[lane_q];
  assign out_index = index_q;
  assign out_last  = buf_valid_q && is_last_elem;

  // Job sequencing, word buffering and element index tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      num_q         <= '0;
      words_tot_q   <= '0;
      words_taken_q <= '0;
      index_q       <= '0;
      buf_q         <= '0;
      buf_valid_q   <= 1'b0;
      lane_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_elems == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q       <= S_RUN;
              num_q         <= num_elems;
              words_tot_q   <= words_tot_d;
              words_taken_q <= '0;
              index_q       <= '0;
              lane_q        <= '0;
              buf_valid_q   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (out_fire) begin
            index_q <= index_q + 1'b1;
            if (is_last_elem) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
          if (in_fire) begin
            buf_q         <= in_data;
            buf_valid_q   <= 1'b1;
            lane_q        <= '0;
            words_taken_q <= words_taken_q + 1'b1;
          end else if (word_release) begin
            buf_valid_q <= 1'b0;
          end else if (out_fire) begin
            lane_q <= lane_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
